pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and reset, with synchronous active-low reset; port rows give name, direction, width, meaning.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low (`RstEnable` = 0).
REQ-004 jump_req_i  in  1  taken branch/jump resolved in EX this cycle.
REQ-005 jump_addr_i  in  `InstAddrBus` (32)  target of jump_req_i.
REQ-006 ld_stall_req_i  in  1  load-use hazard detected in ID.
REQ-007 div_start_i  in  1  multi-cycle divide entering EX this cycle.
REQ-008 div_done_i  in  1  single-cycle pulse; divider result valid, held until next div_start_i.
REQ-009 mem_wait_i  in  1  data bus not ready; whole pipe must freeze.
REQ-010 cnt_clr_i  in  1  clear stall counter.
REQ-011 hold_en_o  out  5  per-register hold: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb.
REQ-012 flush_o  out  5  per-register bubble insert, same bit map; hold wins over flush on the same bit.
REQ-013 jump_en_o  out  1  pc loads jump_addr_o next edge.
REQ-014 jump_addr_o  out  32  equals jump_addr_i when jump_en_o = 1, else 0.
REQ-015 stall_cnt_o  out  32  count of cycles with hold_en_o[0] = 1.

Function
REQ-016 The FSM SHALL have states S_RUN, S_FLUSH and S_DIV; outputs SHALL be combinational from state and inputs, with the state registered.
REQ-017 In any state, mem_wait_i = 1 SHALL give hold_en_o = 5'b11111, flush_o = 0 and jump_en_o = 0, with the state unchanged except S_DIV per REQ-022.
REQ-018 In S_RUN, priority after mem_wait_i SHALL be: jump_req_i, then div_start_i, then ld_stall_req_i.
REQ-019 In S_RUN with jump_req_i: jump_en_o = 1, flush_o = 5'b00110, hold_en_o = 0, next state S_FLUSH; div_start_i and ld_stall_req_i in the same cycle are dropped (wrong-path).
REQ-020 In S_RUN with div_start_i: hold_en_o = 5'b00111, flush_o = 5'b01000, next state S_DIV.
REQ-021 In S_RUN with ld_stall_req_i only: hold_en_o = 5'b00011, flush_o = 5'b00100, state stays S_RUN; a single-cycle stall repeats while the request stays high.
REQ-022 In S_DIV: hold_en_o = 5'b00111 and flush_o = 5'b01000 until div_done_i; on div_done_i, that cycle SHALL output hold 0 and flush 0 and next state S_RUN, even if mem_wait_i is set (the freeze still applies that cycle).
REQ-023 In S_FLUSH, one cycle only (absorbs the synchronous instruction-RAM latency): flush_o = 5'b00010, hold 0, next state S_RUN; jump_req_i, div_start_i and ld_stall_req_i are ignored.
REQ-024 With no request in S_RUN: hold 0, flush 0, jump_en_o 0.
REQ-025 stall_cnt_o SHALL increment by 1 on each edge where hold_en_o[0] = 1, saturate at 32'hFFFFFFFF, and clear to 0 on cnt_clr_i; clear wins over increment.

Reset
REQ-026 On rising clk with rstn = 0: state S_RUN, stall_cnt_o = 0.
REQ-027 While rstn = 0: hold_en_o = 0, flush_o = 5'b11111, jump_en_o = 0, jump_addr_o = 0; all request inputs ignored.
REQ-028 Reset asserted mid-divide or mid-flush SHALL abandon the operation; the first cycle after release is S_RUN.

Structure
REQ-029 defines.v SHALL hold the state encodings, the hold/flush bit indices (HOLD_PC..HOLD_MEMWB) and `InstAddrBus`.
REQ-030 The saturating stall counter SHALL be a sub-module, perf_cnt (inc, clr, 32-bit value).

Verification
REQ-031 jump_req_i = 1, jump_addr_i = 32'h0000_0100 in S_RUN -> jump_en_o = 1, addr 0x100, flush 00110; next cycle flush 00010; then idle.
REQ-032 div_start_i; div_done_i 5 cycles later -> hold 00111 for 5 cycles, 0 on the done cycle; stall_cnt_o = 5.
REQ-033 ld_stall_req_i high for 2 cycles -> hold 00011 and flush 00100 for 2 cycles; stall_cnt_o = 2.
REQ-034 jump_req_i, div_start_i and mem_wait_i all high -> hold 11111, jump_en_o 0; mem_wait_i drops -> jump taken, div dropped.
REQ-035 rstn low during S_DIV -> flush 11111 and counter 0; after release, S_RUN with hold 0.
REQ-036 Counter preloaded by force to 32'hFFFFFFFE with 3 stall cycles -> holds at FFFFFFFF; cnt_clr_i together with a stall -> 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM states, hold/flush
// bit indices and the instruction address width.
package pipe_ctrl_pkg;

    localparam int unsigned INST_ADDR_W = 32;

    localparam int unsigned HOLD_PC    = 0;
    localparam int unsigned HOLD_IFID  = 1;
    localparam int unsigned HOLD_IDEX  = 2;
    localparam int unsigned HOLD_EXMEM = 3;
    localparam int unsigned HOLD_MEMWB = 4;

    localparam int unsigned NUM_STAGES = 5;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DIV   = 2'd2
    } state_t;

    // Build a stage mask from the individual per-register bits
    function automatic logic [NUM_STAGES-1:0] stage_mask(
        input logic pc, input logic ifid, input logic idex,
        input logic exmem, input logic memwb);
        logic [NUM_STAGES-1:0] m;
        m             = '0;
        m[HOLD_PC]    = pc;
        m[HOLD_IFID]  = ifid;
        m[HOLD_IDEX]  = idex;
        m[HOLD_EXMEM] = exmem;
        m[HOLD_MEMWB] = memwb;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Saturating 32-bit event counter; clear has priority over increment.
module perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] value
);

    logic [31:0] cnt_q;

    // Count qualifying cycles, stick at all-ones, clear on reset or request
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-register hold/flush generation for
// jumps, multi-cycle divides, load-use stalls and data-bus wait states.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   jump_req_i,
    input  logic [INST_ADDR_W-1:0] jump_addr_i,
    input  logic                   ld_stall_req_i,
    input  logic                   div_start_i,
    input  logic                   div_done_i,
    input  logic                   mem_wait_i,
    input  logic                   cnt_clr_i,
    output logic [4:0]             hold_en_o,
    output logic [4:0]             flush_o,
    output logic                   jump_en_o,
    output logic [INST_ADDR_W-1:0] jump_addr_o,
    output logic [31:0]            stall_cnt_o
);

    state_t state_q, state_d;
    logic [4:0] hold_c, flush_c;
    logic       jump_c;

    // State register; reset abandons any divide or flush in progress
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and hold/flush/jump decode
    always_comb begin
        state_d = state_q;
        hold_c  = '0;
        flush_c = '0;
        jump_c  = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (mem_wait_i) begin
                    hold_c = '1;
                end else if (jump_req_i) begin
                    jump_c  = 1'b1;
                    flush_c = stage_mask(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                    state_d = S_FLUSH;
                end else if (div_start_i) begin
                    hold_c  = stage_mask(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                    flush_c = stage_mask(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    state_d = S_DIV;
                end else if (ld_stall_req_i) begin
                    hold_c  = stage_mask(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                    flush_c = stage_mask(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                end
            end
            S_FLUSH: begin
                if (mem_wait_i) begin
                    hold_c = '1;
                end else begin
                    flush_c = stage_mask(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    state_d = S_RUN;
                end
            end
            S_DIV: begin
                // Divider completion is a one-cycle pulse, so it must be
                // consumed even while the bus freeze is in effect
                if (div_done_i) begin
                    state_d = S_RUN;
                end
                if (mem_wait_i) begin
                    hold_c = '1;
                end else if (!div_done_i) begin
                    hold_c  = stage_mask(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                    flush_c = stage_mask(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Output gating: reset forces bubbles everywhere; hold beats flush
    always_comb begin
        if (!rstn) begin
            hold_en_o = '0;
            flush_o   = '1;
            jump_en_o = 1'b0;
        end else begin
            hold_en_o = hold_c;
            flush_o   = flush_c & ~hold_c;
            jump_en_o = jump_c;
        end
    end

    assign jump_addr_o = jump_en_o ? jump_addr_i : '0;

    perf_cnt u_perf_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (hold_en_o[HOLD_PC]),
        .clr   (cnt_clr_i),
        .value (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

    logic        clk;
    logic        rstn;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        ld_stall_req_i;
    logic        div_start_i;
    logic        div_done_i;
    logic        mem_wait_i;
    logic        cnt_clr_i;
    logic [4:0]  hold_en_o;
    logic [4:0]  flush_o;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic [31:0] stall_cnt_o;

    int unsigned n_checks;
    int unsigned n_fails;

    pipe_ctrl dut (
        .clk            (clk),
        .rstn           (rstn),
        .jump_req_i     (jump_req_i),
        .jump_addr_i    (jump_addr_i),
        .ld_stall_req_i (ld_stall_req_i),
        .div_start_i    (div_start_i),
        .div_done_i     (div_done_i),
        .mem_wait_i     (mem_wait_i),
        .cnt_clr_i      (cnt_clr_i),
        .hold_en_o      (hold_en_o),
        .flush_o        (flush_o),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the combinational control outputs against expected values
    task automatic check_ctrl(input string tag, input logic [4:0] hold,
                              input logic [4:0] flush, input logic jen);
        #1;
        check({tag, ".hold"},  {27'd0, hold_en_o}, {27'd0, hold});
        check({tag, ".flush"}, {27'd0, flush_o},   {27'd0, flush});
        check({tag, ".jen"},   {31'd0, jump_en_o}, {31'd0, jen});
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        rstn           = 1'b0;
        jump_req_i     = 1'b1;
        jump_addr_i    = 32'h0000_0400;
        ld_stall_req_i = 1'b1;
        div_start_i    = 1'b1;
        div_done_i     = 1'b0;
        mem_wait_i     = 1'b0;
        cnt_clr_i      = 1'b0;

        // Reset: requests ignored, bubbles everywhere
        tick();
        check_ctrl("rst", 5'b00000, 5'b11111, 1'b0);
        check("rst.addr", jump_addr_o, 32'h0);
        check("rst.cnt", stall_cnt_o, 32'h0);
        jump_req_i = 1'b0; ld_stall_req_i = 1'b0; div_start_i = 1'b0;
        rstn = 1'b1;
        check_ctrl("idle0", 5'b00000, 5'b00000, 1'b0);
        tick();

        // Jump then one flush cycle then idle
        jump_req_i = 1'b1; jump_addr_i = 32'h0000_0100;
        check_ctrl("jmp", 5'b00000, 5'b00110, 1'b1);
        check("jmp.addr", jump_addr_o, 32'h0000_0100);
        tick();
        jump_req_i = 1'b0; div_start_i = 1'b1;
        check_ctrl("jflush", 5'b00000, 5'b00010, 1'b0);
        check("jflush.addr", jump_addr_o, 32'h0);
        tick();
        div_start_i = 1'b0;
        check_ctrl("jidle", 5'b00000, 5'b00000, 1'b0);
        check("jidle.cnt", stall_cnt_o, 32'd0);

        // Load-use stall, two cycles
        ld_stall_req_i = 1'b1;
        check_ctrl("ld1", 5'b00011, 5'b00100, 1'b0);
        tick();
        check_ctrl("ld2", 5'b00011, 5'b00100, 1'b0);
        tick();
        ld_stall_req_i = 1'b0;
        check_ctrl("ldend", 5'b00000, 5'b00000, 1'b0);
        check("ld.cnt", stall_cnt_o, 32'd2);

        // Clear counter
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        check("clr.cnt", stall_cnt_o, 32'd0);

        // Divide: done 5 cycles after start
        div_start_i = 1'b1;
        check_ctrl("div0", 5'b00111, 5'b01000, 1'b0);
        tick();
        div_start_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            check_ctrl("divw", 5'b00111, 5'b01000, 1'b0);
            tick();
        end
        div_done_i = 1'b1;
        check_ctrl("divdone", 5'b00000, 5'b00000, 1'b0);
        tick();
        div_done_i = 1'b0;
        check_ctrl("divrun", 5'b00000, 5'b00000, 1'b0);
        check("div.cnt", stall_cnt_o, 32'd5);

        // Freeze beats jump/div; then jump wins, div dropped
        jump_req_i = 1'b1; div_start_i = 1'b1; mem_wait_i = 1'b1;
        jump_addr_i = 32'h0000_0200;
        check_ctrl("mw", 5'b11111, 5'b00000, 1'b0);
        check("mw.addr", jump_addr_o, 32'h0);
        tick();
        mem_wait_i = 1'b0;
        check_ctrl("mwjmp", 5'b00000, 5'b00110, 1'b1);
        check("mwjmp.addr", jump_addr_o, 32'h0000_0200);
        tick();
        jump_req_i = 1'b0; div_start_i = 1'b0;
        check_ctrl("mwflush", 5'b00000, 5'b00010, 1'b0);
        tick();
        check_ctrl("mwidle", 5'b00000, 5'b00000, 1'b0);
        check("mw.cnt", stall_cnt_o, 32'd6);

        // Divide completion during a bus freeze still returns to run
        div_start_i = 1'b1;
        tick();
        div_start_i = 1'b0; div_done_i = 1'b1; mem_wait_i = 1'b1;
        check_ctrl("dmw", 5'b11111, 5'b00000, 1'b0);
        tick();
        div_done_i = 1'b0; mem_wait_i = 1'b0;
        check_ctrl("dmwrun", 5'b00000, 5'b00000, 1'b0);
        check("dmw.cnt", stall_cnt_o, 32'd8);

        // Reset in the middle of a divide
        div_start_i = 1'b1;
        tick();
        div_start_i = 1'b0;
        rstn = 1'b0;
        check_ctrl("rdiv", 5'b00000, 5'b11111, 1'b0);
        tick();
        check("rdiv.cnt", stall_cnt_o, 32'd0);
        rstn = 1'b1;
        check_ctrl("rdivrun", 5'b00000, 5'b00000, 1'b0);
        tick();
        check_ctrl("rdivrun2", 5'b00000, 5'b00000, 1'b0);

        // Saturation near all-ones, then clear beats increment
        force dut.u_perf_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_perf_cnt.cnt_q;
        check("pre.cnt", stall_cnt_o, 32'hFFFF_FFFE);
        ld_stall_req_i = 1'b1;
        tick();
        check("sat1.cnt", stall_cnt_o, 32'hFFFF_FFFF);
        tick();
        tick();
        check("sat3.cnt", stall_cnt_o, 32'hFFFF_FFFF);
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        ld_stall_req_i = 1'b0;
        check("clrinc.cnt", stall_cnt_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
